// File: rtl/calib_pulse_ctr_if.sv
// ---------------------------------------------------------------------------
// calib_pulse_ctr_if
//   Bundles the calibration-pulse monitor's data and control signals.
//
//   PULSE_IN  [NCH]        raw pulse levels, asynchronous to CLK40
//   EN        [NCH]        per-channel count enable
//   DEADTIME  [DEAD_W]     hold-off cycles after each accepted edge
//   CLR_CNT                1-cycle synchronous clear strobe
//   SNAP                   1-cycle snapshot strobe
//   EDGE_OUT  [NCH]        1-cycle flag per accepted edge
//   CNT_OUT   [NCH*CNT_W]  live counters, channel i at [i*CNT_W +: CNT_W]
//   SNAP_OUT  [NCH*CNT_W]  snapshot registers, same packing as CNT_OUT
//   SNAP_VLD               1-cycle pulse, the cycle after SNAP
//   OVF       [NCH]        sticky overflow flags
//
//   master : the controller side (drives pulses and strobes)
//   slave  : the monitor itself
// ---------------------------------------------------------------------------
interface calib_pulse_ctr_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned DEAD_W = 4
);
    logic [NCH-1:0]       PULSE_IN;
    logic [NCH-1:0]       EN;
    logic [DEAD_W-1:0]    DEADTIME;
    logic                 CLR_CNT;
    logic                 SNAP;
    logic [NCH-1:0]       EDGE_OUT;
    logic [NCH*CNT_W-1:0] CNT_OUT;
    logic [NCH*CNT_W-1:0] SNAP_OUT;
    logic                 SNAP_VLD;
    logic [NCH-1:0]       OVF;

    modport master (
        output PULSE_IN, EN, DEADTIME, CLR_CNT, SNAP,
        input  EDGE_OUT, CNT_OUT, SNAP_OUT, SNAP_VLD, OVF
    );

    modport slave (
        input  PULSE_IN, EN, DEADTIME, CLR_CNT, SNAP,
        output EDGE_OUT, CNT_OUT, SNAP_OUT, SNAP_VLD, OVF
    );
endinterface

// File: rtl/calib_pulse_ctr.sv
// ---------------------------------------------------------------------------
// calib_pulse_ctr
//   Calibration-pulse monitor for NCH channels. Each channel is synchronised
//   to CLK40, edge-detected, filtered by a programmable dead-time and counted
//   in a CNT_W-bit counter (wrap or saturate). A snapshot path copies all
//   counters at once; SNAP together with CLR_CNT is an atomic read-and-clear.
//   The monitored pulses themselves are not touched or delayed.
//
//   Ports:
//     CLK40       40 MHz system clock
//     rst_resync  asynchronous active-high reset (RST or RESYNC)
//     bus         calib_pulse_ctr_if.slave - pulses, enables, dead-time,
//                 strobes in; edge flags, counters, snapshot, overflow out
//
//   Parameters:
//     NCH       number of channels (1..16)
//     CNT_W     counter width (2..32)
//     SATURATE  0 = wrap to 0 on overflow, 1 = hold at all-ones
//     DEAD_W    width of the DEADTIME field
// ---------------------------------------------------------------------------
module calib_pulse_ctr #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned DEAD_W   = 4
) (
    input  logic             CLK40,
    input  logic             rst_resync,
    calib_pulse_ctr_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ch_state_t;

    // Input path: s1/s2 synchroniser, s3 history, r_edge registered edge.
    logic [NCH-1:0]    r_s1;
    logic [NCH-1:0]    r_s2;
    logic [NCH-1:0]    r_s3;
    logic [NCH-1:0]    r_edge;
    logic [1:0]        r_warm;
    logic              w_ready;
    logic [NCH-1:0]    w_raw;

    // Per-channel state.
    ch_state_t         r_state [NCH];
    logic [DEAD_W-1:0] r_hold  [NCH];
    logic [CNT_W-1:0]  r_cnt   [NCH];
    logic [CNT_W-1:0]  r_snap  [NCH];
    logic [NCH-1:0]    r_edge_out;
    logic [NCH-1:0]    r_ovf;
    logic              r_snap_vld;

    // -----------------------------------------------------------------------
    // Synchroniser and edge detect.
    // After reset every stage is 0, so a pulse already high at release would
    // look like a rising edge while it walks through s1/s2. Edges are masked
    // until three clocks after release, by which time s3 holds the synced
    // level and a held-high input can no longer produce an edge.
    // The extra r_edge register fixes the input-to-count latency at 3 clocks
    // after the first high sample.
    // -----------------------------------------------------------------------
    assign w_ready = (r_warm == 2'd3);
    assign w_raw   = r_s2 & ~r_s3 & {NCH{w_ready}};

    always_ff @(posedge CLK40 or posedge rst_resync) begin
        if (rst_resync) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_edge <= '0;
            r_warm <= '0;
        end else begin
            r_s1   <= bus.PULSE_IN;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_edge <= w_raw;
            if (!w_ready) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel dead-time FSM and counter.
    // IDLE: accept an enabled edge, count it, load hold-off from DEADTIME.
    // HOLD: count hold-off down regardless of EN; edges are dropped.
    // CLR_CNT wins over an edge accepted in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK40 or posedge rst_resync) begin
        if (rst_resync) begin
            r_edge_out <= '0;
            r_ovf      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_state[i] <= ST_IDLE;
                r_hold[i]  <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_edge_out[i] <= 1'b0;
                if (bus.CLR_CNT) begin
                    r_cnt[i]   <= '0;
                    r_ovf[i]   <= 1'b0;
                    r_hold[i]  <= '0;
                    r_state[i] <= ST_IDLE;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (r_edge[i] && bus.EN[i]) begin
                                r_edge_out[i] <= 1'b1;
                                if (r_cnt[i] == '1) begin
                                    r_ovf[i] <= 1'b1;
                                    if (SATURATE == 0) begin
                                        r_cnt[i] <= '0;
                                    end
                                end else begin
                                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                                end
                                r_hold[i] <= bus.DEADTIME;
                                if (bus.DEADTIME != '0) begin
                                    r_state[i] <= ST_HOLD;
                                end
                            end
                        end
                        ST_HOLD: begin
                            r_hold[i] <= r_hold[i] - DEAD_W'(1);
                            if (r_hold[i] == DEAD_W'(1)) begin
                                r_state[i] <= ST_IDLE;
                            end
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Snapshot: captures the pre-update counter registers, so SNAP with
    // CLR_CNT reads the values that are being cleared in the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK40 or posedge rst_resync) begin
        if (rst_resync) begin
            r_snap_vld <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_snap_vld <= bus.SNAP;
            if (bus.SNAP) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    r_snap[i] <= r_cnt[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output packing.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign bus.CNT_OUT[g*CNT_W +: CNT_W]  = r_cnt[g];
        assign bus.SNAP_OUT[g*CNT_W +: CNT_W] = r_snap[g];
    end

    assign bus.EDGE_OUT = r_edge_out;
    assign bus.OVF      = r_ovf;
    assign bus.SNAP_VLD = r_snap_vld;

endmodule

// File: doc/calib_pulse_ctr.md
Name: calib_pulse_ctr

Overview:
Parametrised calibration-pulse monitor for NCH pulse channels, e.g. channel 0 = injection pulse and channel 1 = external pulse. Each channel is synchronised to CLK40, edge-detected and filtered by a programmable dead-time. Accepted edges are counted in per-channel counters of width CNT_W, with selectable wrap or saturate behaviour. An atomic snapshot / read-and-clear path lets slow control read every counter coherently. The block sits after the calibration source mux and monitors the already-selected pulses without delaying them.

Parameters:
NCH, 2, number of monitored pulse channels (1..16)
CNT_W, 12, counter width per channel (2..32)
SATURATE, 0, 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones
DEAD_W, 4, width of the DEADTIME field

Ports:
CLK40  in  1  40 MHz system clock
rst_resync  in  1  asynchronous active-high reset (RST or RESYNC)
PULSE_IN  in  NCH  raw pulse levels, asynchronous to CLK40
EN  in  NCH  per-channel count enable
DEADTIME  in  DEAD_W  hold-off cycles after each accepted edge; quasi-static
CLR_CNT  in  1  synchronous clear strobe, 1 cycle
SNAP  in  1  snapshot strobe, 1 cycle
EDGE_OUT  out  NCH  registered 1-cycle flag per accepted edge
CNT_OUT  out  NCH*CNT_W  live counters; channel i at [i*CNT_W +: CNT_W]
SNAP_OUT  out  NCH*CNT_W  snapshot registers, same packing as CNT_OUT
SNAP_VLD  out  1  1-cycle pulse, cycle after SNAP
OVF  out  NCH  sticky overflow flag per channel

Behaviour:
- Reset is decided: rst_resync, asynchronous, active-high; clock CLK40.
- Reset clears every flop to 0, including synchronisers, edge-detect history and hold-off counters. Outputs are therefore CNT_OUT=0, SNAP_OUT=0, SNAP_VLD=0, OVF=0, EDGE_OUT=0.
- Reset asserted mid-hold-off or mid-pulse aborts all activity. A PULSE_IN still high at reset release is not counted: the history flop takes the synced high value before any edge can be seen.
- Per channel, the input path is a 2-flop synchroniser (s1, s2) followed by a history flop s3.
- Raw edge = s2 & ~s3.
- Latency: if PULSE_IN rises and is first sampled high at edge k, the counter increments and EDGE_OUT asserts on edge k+3. This latency is fixed.
- Per-channel state machine:
  - IDLE (holdoff == 0): a raw edge with EN=1 is accepted. The counter increments, EDGE_OUT pulses, and holdoff loads DEADTIME. If DEADTIME != 0 the channel goes to HOLD; if DEADTIME == 0 it stays in IDLE.
  - HOLD (holdoff != 0): holdoff decrements by 1 each cycle. Raw edges are rejected (no count, no EDGE_OUT) and holdoff is not reloaded. The channel returns to IDLE when holdoff reaches 0.
  - Result: edges arriving 1..DEADTIME cycles after an accepted edge are rejected; an edge arriving DEADTIME+1 cycles after is accepted.
- EN=0: edges are ignored, holdoff is not loaded, the counter holds, and an in-progress holdoff keeps decrementing.
- Counter overflow when the counter is at all-ones and an edge is accepted:
  - SATURATE=0: counter goes to 0.
  - SATURATE=1: counter stays at all-ones.
  - In both modes OVF[i] is set and stays set until CLR_CNT or reset. EDGE_OUT still pulses.
- CLR_CNT: on the next edge, all counters, OVF and holdoff are cleared. CLR_CNT has priority over an edge accepted in the same cycle: that edge is lost and EDGE_OUT stays 0. Synchroniser and history flops are not cleared.
- SNAP: on the next edge, SNAP_OUT captures the current CNT_OUT registers (pre-increment value; an edge accepted in the same cycle is not included). SNAP_VLD is 1 for that one cycle. SNAP_OUT holds until the next SNAP or reset.
- SNAP and CLR_CNT in the same cycle: SNAP_OUT captures the pre-clear values and the counters then clear. This is the atomic read-and-clear; no edge is lost between read and clear other than the same-cycle edge lost per the CLR_CNT rule.
- Channels are fully independent; simultaneous edges on all channels are all counted.
- Arithmetic is unsigned at CNT_W bits; the holdoff counter is DEAD_W bits.

Test Plan:
1. Latency/basic: DEADTIME=0, EN=2'b11, PULSE_IN[0] high for 3 cycles, 5 times, 4-cycle gaps -> CNT_OUT[11:0]=5, channel 1=0; each EDGE_OUT[0] pulse 3 edges after first high sample; OVF=0.
2. Dead-time: DEADTIME=5, 2-cycle pulses on ch1 spaced 4 cycles (edges at t, t+4, t+8) -> accepts t and t+8, rejects t+4; count=2. Repeat with spacing 6 -> all 3 counted.
3. Wrap/saturate: CNT_W=4. SATURATE=0: 17 pulses -> count=1, OVF=1. SATURATE=1: 17 pulses -> count=15, OVF=1.
4. Read-and-clear: count ch0=7, ch1=3; assert SNAP and CLR_CNT together -> next cycle SNAP_OUT={3,7}, SNAP_VLD=1, CNT_OUT=0, OVF=0. Then an edge arriving together with CLR_CNT is not counted.
5. Reset mid-operation: DEADTIME=15, accept edge, assert rst_resync 3 cycles later while PULSE_IN held high -> all outputs 0 immediately. After release, no count until PULSE_IN goes low then high; next edge is accepted (holdoff cleared).
6. Enable gating: EN[0]=0 during 4 pulses, then EN[0]=1 for 2 pulses -> count=2, EDGE_OUT only on the last 2.
